mvm_lanes: RTL and testbench

- Parametrised successor to the single-MAC matrix-vector multiplier. Computes y = A·x + b for an NROWS x NCOLS signed matrix A, bias vector b and vector x.
- All operands arrive on one 8-bit-style valid/ready input stream. Results leave one per beat on a valid/ready output stream.
- NLANES MAC lanes compute NLANES rows in parallel.
- Adds a selectable saturate/wrap mode and a keep-matrix mode, so that a new x can be streamed without reloading A and b.

---
 rtl/defines_pkg.sv | 28 ++
 rtl/mvm_lane.sv | 58 +++++
 rtl/mvm_mem.sv | 23 ++
 rtl/mvm_lanes.sv | 227 ++++++++++++++++++++++
 tb/tb_mvm_lanes.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/defines_pkg.sv
// Shared types, default sizes and width helpers for the lane-parallel matrix-vector multiplier.
package defines_pkg;

  typedef enum logic [2:0] {
    StLoadA,
    StLoadB,
    StLoadX,
    StCompute,
    StDrain
  } state_e;

  localparam int unsigned DefInW    = 8;
  localparam int unsigned DefOutW   = 16;
  localparam int unsigned DefNRows  = 4;
  localparam int unsigned DefNCols  = 4;
  localparam int unsigned DefNLanes = 2;

  // Wide enough that NCOLS products plus the bias can never overflow.
  function automatic int unsigned acc_w(input int unsigned in_w, input int unsigned ncols);
    return 2 * in_w + $clog2(ncols + 1) + 1;
  endfunction

  // Counter/address width that never collapses to zero bits.
  function automatic int unsigned cw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvm_lane.sv
// One MAC lane: bias preload, signed multiply-accumulate, range check and saturate/wrap.
module mvm_lane
  import defines_pkg::*;
#(
  parameter int unsigned IN_W   = DefInW,
  parameter int unsigned OUT_W  = DefOutW,
  parameter int unsigned NCOLS  = DefNCols,
  parameter int unsigned SAT_EN = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             preload,
  input  logic             mac_en,
  input  logic [IN_W-1:0]  bias,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] result,
  output logic             overflow
);

  localparam int unsigned ACC_W = acc_w(IN_W, NCOLS);
  localparam int unsigned PW    = 2 * IN_W;

  localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc_q;
  logic signed [PW-1:0]    a_ext, x_ext, prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic                    hi, lo;

  assign a_ext    = PW'($signed(a));
  assign x_ext    = PW'($signed(x));
  assign prod     = a_ext * x_ext;
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else if (preload) begin
      acc_q <= ACC_W'($signed(bias));
    end else if (mac_en) begin
      acc_q <= acc_q + prod_ext;
    end
  end

  always_comb begin
    hi       = acc_q > OMAX;
    lo       = acc_q < OMIN;
    overflow = hi || lo;
    result   = acc_q[OUT_W-1:0];
    if (SAT_EN != 0) begin
      if (hi) result = OMAX[OUT_W-1:0];
      else if (lo) result = OMIN[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/mvm_mem.sv
// Simple dual-port memory with one-cycle registered read; contents are never reset.
module mvm_mem
  import defines_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [cw(DEPTH)-1:0] waddr,
  input  logic [W-1:0]         wdata,
  input  logic [cw(DEPTH)-1:0] raddr,
  output logic [W-1:0]         rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mvm_lanes.sv
// y = A*x + b with NLANES rows computed in parallel; operands in and results out on
// valid/ready streams, optionally reusing A and b across passes.
module mvm_lanes
  import defines_pkg::*;
#(
  parameter int unsigned IN_W   = DefInW,
  parameter int unsigned OUT_W  = DefOutW,
  parameter int unsigned NROWS  = DefNRows,
  parameter int unsigned NCOLS  = DefNCols,
  parameter int unsigned NLANES = DefNLanes,
  parameter int unsigned SAT_EN = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  input  logic             keep_ab,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_overflow,
  output logic             m_last
);

  localparam int unsigned NGROUPS = NROWS / NLANES;
  localparam int unsigned COL_W   = cw(NCOLS);
  localparam int unsigned LANE_W  = cw(NLANES);
  localparam int unsigned GRP_W   = cw(NGROUPS);
  localparam int unsigned AA_W    = cw(NGROUPS * NCOLS);
  localparam int unsigned CYC_W   = cw(NCOLS + 2);

  if (NLANES == 0 || (NROWS % NLANES) != 0) begin : g_bad_cfg
    $fatal(1, "mvm_lanes: NLANES must divide NROWS");
  end

  state_e              state_q;
  logic [COL_W-1:0]    ld_col_q;
  logic [LANE_W-1:0]   ld_lane_q, didx_q, didx_nxt;
  logic [GRP_W-1:0]    ld_grp_q, grp_q;
  logic [CYC_W-1:0]    cyc_q;
  logic                held_q, buf_last_q;
  logic                m_valid_q, m_ovf_q, m_last_q;
  logic [OUT_W-1:0]    m_data_q;
  logic [OUT_W-1:0]    buf_data_q [NLANES];
  logic                buf_ovf_q  [NLANES];
  logic [OUT_W-1:0]    lane_data  [NLANES];
  logic                lane_ovf   [NLANES];

  logic                fire, preload, mac_en, last_g;
  logic                col_last, lane_last, grp_last;
  logic [COL_W-1:0]    col_rd;
  logic [AA_W-1:0]     a_waddr, a_raddr;
  logic [IN_W-1:0]     x_rd;

  always_comb begin
    s_ready   = (state_q == StLoadA) || (state_q == StLoadB) || (state_q == StLoadX);
    fire      = s_valid && s_ready;
    col_last  = ld_col_q == COL_W'(NCOLS - 1);
    lane_last = ld_lane_q == LANE_W'(NLANES - 1);
    grp_last  = ld_grp_q == GRP_W'(NGROUPS - 1);
    last_g    = grp_q == GRP_W'(NGROUPS - 1);
    didx_nxt  = didx_q + LANE_W'(1);
    col_rd    = (cyc_q < CYC_W'(NCOLS)) ? cyc_q[COL_W-1:0] : '0;
    a_waddr   = AA_W'(ld_grp_q) * AA_W'(NCOLS) + AA_W'(ld_col_q);
    a_raddr   = AA_W'(grp_q) * AA_W'(NCOLS) + AA_W'(col_rd);
    preload   = (state_q == StCompute) && (cyc_q == '0);
    mac_en    = (state_q == StCompute) && (cyc_q != '0) && (cyc_q <= CYC_W'(NCOLS));
  end

  mvm_mem #(.W(IN_W), .DEPTH(NCOLS)) u_x_mem (
    .clk   (clk),
    .we    (fire && (state_q == StLoadX)),
    .waddr (ld_col_q),
    .wdata (s_data),
    .raddr (col_rd),
    .rdata (x_rd)
  );

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    logic [IN_W-1:0] a_rd, b_rd;

    mvm_mem #(.W(IN_W), .DEPTH(NGROUPS * NCOLS)) u_a_mem (
      .clk   (clk),
      .we    (fire && (state_q == StLoadA) && (ld_lane_q == LANE_W'(l))),
      .waddr (a_waddr),
      .wdata (s_data),
      .raddr (a_raddr),
      .rdata (a_rd)
    );

    // grp_q already points at the upcoming group while idle, so bias is ready at cycle 0.
    mvm_mem #(.W(IN_W), .DEPTH(NGROUPS)) u_b_mem (
      .clk   (clk),
      .we    (fire && (state_q == StLoadB) && (ld_lane_q == LANE_W'(l))),
      .waddr (ld_grp_q),
      .wdata (s_data),
      .raddr (grp_q),
      .rdata (b_rd)
    );

    mvm_lane #(.IN_W(IN_W), .OUT_W(OUT_W), .NCOLS(NCOLS), .SAT_EN(SAT_EN)) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .preload  (preload),
      .mac_en   (mac_en),
      .bias     (b_rd),
      .a        (a_rd),
      .x        (x_rd),
      .result   (lane_data[l]),
      .overflow (lane_ovf[l])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StLoadA;
      ld_col_q   <= '0;
      ld_lane_q  <= '0;
      ld_grp_q   <= '0;
      grp_q      <= '0;
      cyc_q      <= '0;
      didx_q     <= '0;
      held_q     <= 1'b0;
      buf_last_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_ovf_q    <= 1'b0;
      m_last_q   <= 1'b0;
      for (int i = 0; i < NLANES; i++) begin
        buf_data_q[i] <= '0;
        buf_ovf_q[i]  <= 1'b0;
      end
    end else begin
      unique case (state_q)
        StLoadA: if (fire) begin
          if (!col_last) begin
            ld_col_q <= ld_col_q + COL_W'(1);
          end else begin
            ld_col_q <= '0;
            if (!lane_last) begin
              ld_lane_q <= ld_lane_q + LANE_W'(1);
            end else begin
              ld_lane_q <= '0;
              if (!grp_last) begin
                ld_grp_q <= ld_grp_q + GRP_W'(1);
              end else begin
                ld_grp_q <= '0;
                state_q  <= StLoadB;
              end
            end
          end
        end
        StLoadB: if (fire) begin
          if (!lane_last) begin
            ld_lane_q <= ld_lane_q + LANE_W'(1);
          end else begin
            ld_lane_q <= '0;
            if (!grp_last) begin
              ld_grp_q <= ld_grp_q + GRP_W'(1);
            end else begin
              ld_grp_q <= '0;
              held_q   <= 1'b1;
              state_q  <= StLoadX;
            end
          end
        end
        StLoadX: if (fire) begin
          if (!col_last) begin
            ld_col_q <= ld_col_q + COL_W'(1);
          end else begin
            ld_col_q <= '0;
            cyc_q    <= '0;
            state_q  <= StCompute;
          end
        end
        StCompute: begin
          if (cyc_q == CYC_W'(NCOLS + 1)) begin
            for (int i = 0; i < NLANES; i++) begin
              buf_data_q[i] <= lane_data[i];
              buf_ovf_q[i]  <= lane_ovf[i];
            end
            m_valid_q  <= 1'b1;
            m_data_q   <= lane_data[0];
            m_ovf_q    <= lane_ovf[0];
            m_last_q   <= last_g && (NLANES == 1);
            buf_last_q <= last_g;
            didx_q     <= '0;
            grp_q      <= last_g ? '0 : grp_q + GRP_W'(1);
            state_q    <= StDrain;
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end
        StDrain: if (m_valid_q && m_ready) begin
          if (didx_q == LANE_W'(NLANES - 1)) begin
            m_valid_q <= 1'b0;
            if (m_last_q) begin
              m_last_q <= 1'b0;
              if (keep_ab && held_q) begin
                state_q <= StLoadX;
              end else begin
                held_q  <= 1'b0;
                state_q <= StLoadA;
              end
            end else begin
              cyc_q   <= '0;
              state_q <= StCompute;
            end
          end else begin
            didx_q   <= didx_nxt;
            m_data_q <= buf_data_q[didx_nxt];
            m_ovf_q  <= buf_ovf_q[didx_nxt];
            m_last_q <= buf_last_q && (didx_nxt == LANE_W'(NLANES - 1));
          end
        end
        default: state_q <= StLoadA;
      endcase
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_overflow = m_ovf_q;
  assign m_last     = m_last_q;

endmodule

// File: tb/tb_mvm_lanes.sv
// Directed bench: a wrapping and a saturating instance share one stimulus stream.
module tb_mvm_lanes;

  logic        clk;
  logic        reset_n;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        keep_ab;
  logic        m_ready;
  logic        s_ready_w, s_ready_s;
  logic        m_valid_w, m_valid_s;
  logic [15:0] m_data_w, m_data_s;
  logic        m_ovf_w, m_ovf_s;
  logic        m_last_w, m_last_s;

  int tests = 0;
  int fails = 0;
  int last_wait = 0;
  int am [16];
  int bv [4];
  int xv [4];

  mvm_lanes #(.SAT_EN(0)) dut_w (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready_w),
    .s_data     (s_data),
    .keep_ab    (keep_ab),
    .m_valid    (m_valid_w),
    .m_ready    (m_ready),
    .m_data     (m_data_w),
    .m_overflow (m_ovf_w),
    .m_last     (m_last_w)
  );

  mvm_lanes #(.SAT_EN(1)) dut_s (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready_s),
    .s_data     (s_data),
    .keep_ab    (keep_ab),
    .m_valid    (m_valid_s),
    .m_ready    (m_ready),
    .m_data     (m_data_s),
    .m_overflow (m_ovf_s),
    .m_last     (m_last_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int v, input int gap_max);
    int n = 0;
    int g;
    g = $urandom_range(0, gap_max);
    for (int i = 0; i < g; i++) @(negedge clk);
    s_data  = 8'(v);
    s_valid = 1'b1;
    while (!s_ready_w && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("s_ready_wait", int'(s_ready_w), 1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic load(input bit full, input int gap_max);
    if (full) begin
      for (int i = 0; i < 16; i++) send(am[i], gap_max);
      for (int i = 0; i < 4; i++) send(bv[i], gap_max);
    end
    for (int i = 0; i < 4; i++) send(xv[i], gap_max);
  endtask

  task automatic recv(input int ew, input int es, input int eo, input int el, input int hold,
                      input string tag);
    int n = 0;
    while (!m_valid_w && n < 50) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    chk({tag, "_valid"}, int'(m_valid_w), 1);
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_data"}, int'($signed(m_data_w)), ew);
      chk({tag, "_hold_valid"}, int'(m_valid_w), 1);
      chk({tag, "_hold_sready"}, int'(s_ready_w), 0);
      @(negedge clk);
    end
    chk({tag, "_data_wrap"}, int'($signed(m_data_w)), ew);
    chk({tag, "_data_sat"}, int'($signed(m_data_s)), es);
    chk({tag, "_ovf_wrap"}, int'(m_ovf_w), eo);
    chk({tag, "_ovf_sat"}, int'(m_ovf_s), eo);
    chk({tag, "_last_wrap"}, int'(m_last_w), el);
    chk({tag, "_last_sat"}, int'(m_last_s), el);
    chk({tag, "_valid_sat"}, int'(m_valid_s), 1);
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic set_identity;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) am[r*4+c] = (r == c) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      bv[i] = 0;
      xv[i] = i + 1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    keep_ab = 1'b0;
    m_ready = 1'b0;
    #12;
    chk("rst_m_valid", int'(m_valid_w), 0);
    chk("rst_s_ready", int'(s_ready_w), 1);
    chk("rst_m_data", int'(m_data_w), 0);
    chk("rst_m_ovf", int'(m_ovf_w), 0);
    chk("rst_m_last", int'(m_last_w), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Identity matrix, with first-result latency check.
    set_identity();
    load(1'b1, 0);
    recv(1, 1, 0, 0, 0, "t1_y0");
    chk("t1_latency", last_wait, 6);
    recv(2, 2, 0, 0, 0, "t1_y1");
    recv(3, 3, 0, 0, 0, "t1_y2");
    recv(4, 4, 0, 1, 0, "t1_y3");
    chk("t1_valid_drop", int'(m_valid_w), 0);
    chk("t1_sready_after", int'(s_ready_w), 1);

    // All -1 matrix with input gaps, backpressure on row 1, keep_ab at the end.
    for (int i = 0; i < 16; i++) am[i] = -1;
    for (int i = 0; i < 4; i++) begin
      bv[i] = 10 * (i + 1);
      xv[i] = 1;
    end
    load(1'b1, 2);
    recv(6, 6, 0, 0, 0, "t2_y0");
    recv(16, 16, 0, 0, 5, "t2_y1");
    recv(26, 26, 0, 0, 0, "t2_y2");
    keep_ab = 1'b1;
    recv(36, 36, 0, 1, 0, "t2_y3");
    keep_ab = 1'b0;
    chk("t2_sready_loadx", int'(s_ready_w), 1);

    // Reuse A and b: only x is streamed.
    for (int i = 0; i < 4; i++) xv[i] = 2;
    load(1'b0, 0);
    chk("t5_sready_low", int'(s_ready_w), 0);
    recv(2, 2, 0, 0, 0, "t5_y0");
    recv(12, 12, 0, 0, 0, "t5_y1");
    recv(22, 22, 0, 0, 0, "t5_y2");
    recv(32, 32, 0, 1, 0, "t5_y3");

    // Positive overflow: 4*127*127 + 127 = 64643; full reload after keep_ab=0.
    for (int i = 0; i < 16; i++) am[i] = 127;
    for (int i = 0; i < 4; i++) begin
      bv[i] = 127;
      xv[i] = 127;
    end
    load(1'b1, 1);
    recv(-893, 32767, 1, 0, 0, "t3_y0");
    recv(-893, 32767, 1, 0, 0, "t3_y1");
    recv(-893, 32767, 1, 0, 0, "t3_y2");
    recv(-893, 32767, 1, 1, 0, "t3_y3");

    // Negative overflow: -65152 wraps to 384, saturates to -32768.
    for (int i = 0; i < 16; i++) am[i] = -128;
    for (int i = 0; i < 4; i++) bv[i] = -128;
    load(1'b1, 0);
    recv(384, -32768, 1, 0, 0, "t3n_y0");
    recv(384, -32768, 1, 0, 0, "t3n_y1");
    recv(384, -32768, 1, 0, 0, "t3n_y2");
    recv(384, -32768, 1, 1, 0, "t3n_y3");

    // Asynchronous reset during group 1 compute, then full reload.
    set_identity();
    load(1'b1, 0);
    recv(1, 1, 0, 0, 0, "t6_pre_y0");
    recv(2, 2, 0, 0, 0, "t6_pre_y1");
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_m_valid", int'(m_valid_w), 0);
    chk("t6_rst_m_valid_sat", int'(m_valid_s), 0);
    chk("t6_rst_s_ready", int'(s_ready_w), 1);
    keep_ab = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    load(1'b1, 0);
    recv(1, 1, 0, 0, 0, "t6_y0");
    recv(2, 2, 0, 0, 0, "t6_y1");
    recv(3, 3, 0, 0, 0, "t6_y2");
    recv(4, 4, 0, 1, 0, "t6_y3");
    chk("t6_valid_drop", int'(m_valid_w), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
